// File: rtl/avalon_bus_pkg.sv
// Shared types and constants for the chip-select/strobe register-bus initiator.
package avalon_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      RDWAIT,
      RESP
   } state_t;

   // Strobe and read-latency windows both fit 1..15 in this width.
   localparam int CNT_W = 4;

   localparam logic BUS_IDLE_CS_N = 1'b1;
   localparam logic BUS_IDLE_WR_N = 1'b1;
   localparam logic BUS_IDLE_RD_N = 1'b1;

endpackage

// File: rtl/avalon_bus_master.sv
// Single-beat initiator for the chip-select/strobe register bus: takes valid/ready
// commands, drives the strobes for a fixed window and returns read data as a pulse.
module avalon_bus_master
   import avalon_bus_pkg::*;
#(
   parameter int ADDR_W        = 2,
   parameter int DATA_W        = 32,
   parameter int STROBE_CYCLES = 1,
   parameter int RD_LATENCY    = 1
) (
   input  logic              iclk,
   input  logic              ireset,
   // Command handshake: a command transfers on a rising edge where iCmdValid and
   // oCmdReady are both 1; iCmd* are sampled only on that edge.
   input  logic              iCmdValid,
   output logic              oCmdReady,
   input  logic              iCmdWrite,
   input  logic [ADDR_W-1:0] iCmdAddr,
   input  logic [DATA_W-1:0] iCmdData,
   output logic              oWrDone,
   output logic              oRspValid,
   output logic [DATA_W-1:0] oRspData,
   output logic              oChipSelect_n,
   output logic              oWrite_n,
   output logic              oRead_n,
   output logic [ADDR_W-1:0] oAddress,
   output logic [DATA_W-1:0] oData,
   input  logic [DATA_W-1:0] iData,
   output state_t            dbg_state
);

   if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
      $error("avalon_bus_master: STROBE_CYCLES must be in 1..15");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
      $error("avalon_bus_master: RD_LATENCY must be in 1..15");
   end

   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES);
   localparam logic [CNT_W-1:0] RD_LD     = CNT_W'(RD_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_write;

   assign dbg_state = state;

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state         <= IDLE;
         cnt           <= '0;
         is_write      <= 1'b0;
         oCmdReady     <= 1'b0;
         oWrDone       <= 1'b0;
         oRspValid     <= 1'b0;
         oRspData      <= '0;
         oChipSelect_n <= BUS_IDLE_CS_N;
         oWrite_n      <= BUS_IDLE_WR_N;
         oRead_n       <= BUS_IDLE_RD_N;
         oAddress      <= '0;
         oData         <= '0;
      end else begin
         oWrDone   <= 1'b0;
         oRspValid <= 1'b0;
         case (state)
            IDLE: begin
               if (iCmdValid && oCmdReady) begin
                  oAddress      <= iCmdAddr;
                  // A read leaves the last write data on the bus.
                  if (iCmdWrite) oData <= iCmdData;
                  is_write      <= iCmdWrite;
                  cnt           <= STROBE_LD;
                  oCmdReady     <= 1'b0;
                  oChipSelect_n <= 1'b0;
                  oWrite_n      <= ~iCmdWrite;
                  oRead_n       <= iCmdWrite;
                  state         <= STROBE;
               end else begin
                  oCmdReady <= 1'b1;
               end
            end
            STROBE: begin
               if (cnt == CNT_ONE) begin
                  oChipSelect_n <= BUS_IDLE_CS_N;
                  oWrite_n      <= BUS_IDLE_WR_N;
                  oRead_n       <= BUS_IDLE_RD_N;
                  if (is_write) begin
                     oWrDone   <= 1'b1;
                     oCmdReady <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     cnt   <= RD_LD;
                     state <= RDWAIT;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            RDWAIT: begin
               if (cnt == CNT_ONE) begin
                  oRspData  <= iData;
                  oRspValid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            RESP: begin
               oCmdReady <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_bus_master.sv
// Directed bench for avalon_bus_master with a register-file slave and a
// queue-based response scoreboard.
module tb_avalon_bus_master;
   import avalon_bus_pkg::*;

   localparam int S = 3;
   localparam int L = 2;

   logic        iclk = 1'b0;
   logic        ireset = 1'b1;
   logic        iCmdValid = 1'b0;
   logic        oCmdReady;
   logic        iCmdWrite = 1'b0;
   logic [1:0]  iCmdAddr = '0;
   logic [31:0] iCmdData = '0;
   logic        oWrDone;
   logic        oRspValid;
   logic [31:0] oRspData;
   logic        oChipSelect_n;
   logic        oWrite_n;
   logic        oRead_n;
   logic [1:0]  oAddress;
   logic [31:0] oData;
   logic [31:0] iData;
   state_t      dbg_state;

   avalon_bus_master #(
      .ADDR_W(2), .DATA_W(32), .STROBE_CYCLES(S), .RD_LATENCY(L)
   ) dut (
      .iclk(iclk), .ireset(ireset),
      .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
      .iCmdAddr(iCmdAddr), .iCmdData(iCmdData),
      .oWrDone(oWrDone), .oRspValid(oRspValid), .oRspData(oRspData),
      .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
      .oAddress(oAddress), .oData(oData), .iData(iData),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 iclk = ~iclk;

   int e = 0;
   always @(posedge iclk) e <= e + 1;

   // ---------------- slave model ----------------
   logic [31:0] slave_regs [4] = '{32'h0, 32'h0, 32'h0, 32'h12345678};
   int          lat_cnt;

   always @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         lat_cnt <= 0;
      end else begin
         if (!oChipSelect_n && !oWrite_n) slave_regs[oAddress] <= oData;
         if (!oChipSelect_n && !oRead_n) lat_cnt <= L;
         else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
      end
   end

   // Data is only valid in the cycle before the expected capture edge.
   always_comb iData = (lat_cnt == 1) ? slave_regs[oAddress] : 32'hBAD0BAD0;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   int          rd_cyc_q[$];
   int          wr_cyc_q[$];
   logic [31:0] model_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h12345678};
   logic [1:0]  bus_addr = '0;
   logic [31:0] bus_data = '0;
   logic        bus_wr = 1'b0;
   logic [31:0] last_wdata = '0;
   int          cs_len = 0;
   int          idle_len = 99;
   int          last_gap = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
   endtask

   // ---------------- driver tasks ----------------
   // Leaves iCmdValid high on return so a following call issues back-to-back.
   task automatic issue(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                        output int acc);
      int n;
      n = 0;
      iCmdValid = 1'b1;
      iCmdWrite = wr;
      iCmdAddr  = addr;
      iCmdData  = data;
      while (!oCmdReady && n < 100) begin
         @(negedge iclk);
         n++;
      end
      if (!oCmdReady) begin
         check("accept_timeout", 64'(oCmdReady), 64'd1);
         iCmdValid = 1'b0;
         acc = -1;
         return;
      end
      acc = e + 1;
      if (wr) begin
         model_mem[addr] = data;
         wr_cyc_q.push_back(acc + S);
      end else begin
         exp_q.push_back(model_mem[addr]);
         rd_cyc_q.push_back(acc + S + L);
      end
      @(posedge iclk);
      #1;
      bus_addr = addr;
      bus_wr   = wr;
      if (wr) last_wdata = data;
      bus_data = last_wdata;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || wr_cyc_q.size() != 0 || !oCmdReady) && n < 100) begin
         @(negedge iclk);
         n++;
      end
      check("wait_idle_timeout", 64'(n < 100), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"},
            64'({oCmdReady, oChipSelect_n, oWrite_n, oRead_n, oWrDone, oRspValid}),
            64'(6'b011100));
      check({tag, "_addr"}, 64'(oAddress), 64'd0);
      check({tag, "_wdata"}, 64'(oData), 64'd0);
      check({tag, "_rspdata"}, 64'(oRspData), 64'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge iclk) begin
      if (ireset) begin
         cs_len   = 0;
         idle_len = 99;
      end else begin
         if (!oChipSelect_n) begin
            if (cs_len == 0) begin
               last_gap = idle_len;
               idle_len = 0;
            end
            cs_len++;
            check("bus_addr", 64'(oAddress), 64'(bus_addr));
            check("bus_wdata", 64'(oData), 64'(bus_data));
            check("bus_strobes", 64'({oWrite_n, oRead_n}), bus_wr ? 64'd1 : 64'd2);
         end else begin
            if (cs_len != 0) begin
               check("cs_window_len", 64'(cs_len), 64'(S));
               cs_len = 0;
            end
            idle_len++;
            check("strobes_idle", 64'({oWrite_n, oRead_n}), 64'd3);
         end
         if (oWrDone) begin
            if (wr_cyc_q.size() == 0) fail("wrdone_unexpected");
            else check("wrdone_cycle", 64'(e), 64'(wr_cyc_q.pop_front()));
         end
         if (oRspValid) begin
            if (exp_q.size() == 0) begin
               fail("rsp_unexpected");
            end else begin
               check("rsp_data", 64'(oRspData), 64'(exp_q.pop_front()));
               check("rsp_cycle", 64'(e), 64'(rd_cyc_q.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int a1, a2, a3, a4;

      repeat (3) @(negedge iclk);
      check_reset_outputs("por");
      ireset = 1'b0;
      #1 check("ready_at_release", 64'(oCmdReady), 64'd0);
      @(negedge iclk);
      check("ready_after_release", 64'(oCmdReady), 64'd1);

      // Single write
      issue(1'b1, 2'd2, 32'hDEADBEEF, a1);
      iCmdValid = 1'b0;
      @(negedge iclk);
      check("wr_c1_ctl", 64'({oChipSelect_n, oWrite_n, oRead_n}), 64'(3'b001));
      check("wr_c1_addr", 64'(oAddress), 64'd2);
      check("wr_c1_data", 64'(oData), 64'hDEADBEEF);
      repeat (S) @(negedge iclk);
      check("wr_done_ctl", 64'({oChipSelect_n, oWrite_n, oWrDone, oCmdReady}), 64'(4'b1111));
      wait_idle();

      // Single read with latency
      issue(1'b0, 2'd3, 32'h0, a1);
      iCmdValid = 1'b0;
      @(negedge iclk);
      check("rd_c1_read_n", 64'({oChipSelect_n, oRead_n}), 64'd0);
      repeat (S + L) @(negedge iclk);
      check("rd_rsp_pulse", 64'({oRspValid, oCmdReady}), 64'(2'b10));
      check("rd_rsp_data", 64'(oRspData), 64'h12345678);
      @(negedge iclk);
      check("rd_rsp_once", 64'({oRspValid, oCmdReady}), 64'(2'b01));
      wait_idle();

      // Back-to-back with iCmdValid held high
      issue(1'b1, 2'd1, 32'h000000A5, a1);
      issue(1'b0, 2'd1, 32'h0, a2);
      @(negedge iclk);
      #1 check("b2b_idle_gap", 64'(last_gap), 64'd1);
      issue(1'b1, 2'd0, 32'h0F0F0F0F, a3);
      issue(1'b0, 2'd0, 32'h0, a4);
      iCmdValid = 1'b0;
      check("wr_to_rd_spacing", 64'(a2 - a1), 64'(S + 1));
      check("rd_to_wr_spacing", 64'(a3 - a2), 64'(S + L + 2));
      check("wr_to_rd_spacing2", 64'(a4 - a3), 64'(S + 1));
      wait_idle();

      // Stall: toggling command fields without valid
      for (int i = 0; i < 10; i++) begin
         @(negedge iclk);
         iCmdAddr = 2'($urandom_range(0, 3));
         iCmdData = $urandom;
         check("stall_bus",
               64'({oChipSelect_n, oWrite_n, oRead_n, oWrDone, oRspValid, oCmdReady}),
               64'(6'b111001));
      end

      // Reset during cycle 1 of a read
      issue(1'b0, 2'd3, 32'h0, a1);
      iCmdValid = 1'b0;
      @(negedge iclk);
      check("mid_rd_strobe_on", 64'({oChipSelect_n, oRead_n}), 64'd0);
      #2 ireset = 1'b1;
      #1 check("mid_rd_async_off", 64'({oChipSelect_n, oRead_n}), 64'(2'b11));
      check_reset_outputs("mid_rd");
      exp_q.delete();
      rd_cyc_q.delete();
      wr_cyc_q.delete();
      last_wdata = '0;
      bus_data   = '0;
      repeat (2) @(negedge iclk);
      ireset = 1'b0;
      @(negedge iclk);
      check("ready_after_mid_reset", 64'(oCmdReady), 64'd1);
      issue(1'b0, 2'd2, 32'h0, a1);
      iCmdValid = 1'b0;
      wait_idle();
      repeat (S + L + 4) @(negedge iclk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
